// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
//
// Multi-cycle control sequencer for a single-ALU MIPS datapath. Each
// instruction steps through FETCH -> DECODE -> (EXEC -> MEM -> WB | BRANCH |
// JUMP). The sequencer produces ALU, memory, register-file and PC strobes.
// Data-memory accesses wait on dm_ready, and a bounded wait counter aborts the
// access when memory never answers.
//
// Optional feature: define MC_PERF_CNT_EN to add the perf_cycles and
// perf_retired performance counters.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (all outputs forced to 0)
//   opcode       instr[31:26] from the instruction register
//   funct        instr[5:0] from the instruction register
//   alu_zero     ALU zero flag (beq condition)
//   dm_ready     data memory accepted write / read data valid
//   ir_write     latch instruction into IR
//   pc_write     update PC
//   pc_src       00 PC+4, 01 branch target, 10 jump target
//   reg_write    register-file write enable
//   reg_dst      1 = rd, 0 = rt
//   alu_op       00 add, 10 sub, 01 or, 11 lui
//   alu_src_imm  ALU second operand is the immediate
//   dm_write     data memory write enable
//   dm_to_reg    data memory read select (lw)
//   state        current state encoding (debug)
//   instr_done   one-cycle pulse on instruction retire
//   illegal_op   one-cycle pulse on an undecodable instruction
//   mem_timeout  one-cycle pulse when a MEM wait is aborted
//   perf_cycles  non-reset cycle count      (MC_PERF_CNT_EN only)
//   perf_retired retired instruction count  (MC_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module mc_control_fsm #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int PERF_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic              alu_zero,
    input  logic              dm_ready,
    output logic              ir_write,
    output logic              pc_write,
    output logic [1:0]        pc_src,
    output logic              reg_write,
    output logic              reg_dst,
    output logic [1:0]        alu_op,
    output logic              alu_src_imm,
    output logic              dm_write,
    output logic              dm_to_reg,
    output logic [3:0]        state,
    output logic              instr_done,
    output logic              illegal_op,
    output logic              mem_timeout
`ifdef MC_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_cycles,
    output logic [PERF_W-1:0] perf_retired
`endif
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_MEM_RD = 4'd3,
        S_MEM_WR = 4'd4,
        S_WB     = 4'd5,
        S_BRANCH = 4'd6,
        S_JUMP   = 4'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;

    // Wait counter is just wide enough to hold MEM_WAIT_MAX.
    localparam int               CNT_W      = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_MAX_C = CNT_W'(MEM_WAIT_MAX);
    localparam logic             TIMEOUT_EN = (MEM_WAIT_MAX != 0);

    if (PERF_W < 1) begin : g_bad_perf_w
        $error("mc_control_fsm: PERF_W must be at least 1");
    end

    state_t           r_state;
    state_t           w_next_state;
    logic [5:0]       r_opcode;
    logic [5:0]       r_funct;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_in_mem;
    logic             w_timeout;

    // True for every instruction this sequencer knows how to execute.
    function automatic logic f_is_legal(input logic [5:0] op, input logic [5:0] fn);
        logic legal;
        case (op)
            OP_RTYPE: legal = (fn == FN_ADD) || (fn == FN_SUB);
            OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
            default:  legal = 1'b0;
        endcase
        return legal;
    endfunction

    // ALU operation for the EXEC step; also held through MEM and WB.
    function automatic logic [1:0] f_alu_op(input logic [5:0] op, input logic [5:0] fn);
        logic [1:0] sel;
        case (op)
            OP_RTYPE: sel = (fn == FN_SUB) ? 2'b10 : 2'b00;
            OP_ORI:   sel = 2'b01;
            OP_LUI:   sel = 2'b11;
            default:  sel = 2'b00;
        endcase
        return sel;
    endfunction

    // Immediate-operand instructions.
    function automatic logic f_alu_imm(input logic [5:0] op);
        logic imm;
        case (op)
            OP_ORI, OP_LUI, OP_LW, OP_SW: imm = 1'b1;
            default:                      imm = 1'b0;
        endcase
        return imm;
    endfunction

    assign w_in_mem  = (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    // A ready memory on the same cycle wins over the abort.
    assign w_timeout = TIMEOUT_EN && w_in_mem && !dm_ready && (r_wait_cnt == WAIT_MAX_C);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latch opcode/funct in DECODE so later states are immune to IR changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opcode <= 6'd0;
            r_funct  <= 6'd0;
        end else if (r_state == S_DECODE) begin
            r_opcode <= opcode;
            r_funct  <= funct;
        end else begin
            r_opcode <= r_opcode;
            r_funct  <= r_funct;
        end
    end

    // Count unanswered MEM cycles; zero outside MEM so every entry starts fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= {CNT_W{1'b0}};
        end else if (w_in_mem && !dm_ready) begin
            if (r_wait_cnt != WAIT_MAX_C) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end else begin
                r_wait_cnt <= r_wait_cnt;
            end
        end else begin
            r_wait_cnt <= {CNT_W{1'b0}};
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH: w_next_state = S_DECODE;
            S_DECODE: begin
                if (!f_is_legal(opcode, funct)) begin
                    w_next_state = S_FETCH;
                end else if (opcode == OP_BEQ) begin
                    w_next_state = S_BRANCH;
                end else if (opcode == OP_J) begin
                    w_next_state = S_JUMP;
                end else begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_opcode == OP_LW) begin
                    w_next_state = S_MEM_RD;
                end else if (r_opcode == OP_SW) begin
                    w_next_state = S_MEM_WR;
                end else begin
                    w_next_state = S_WB;
                end
            end
            S_MEM_RD: begin
                if (dm_ready) begin
                    w_next_state = S_WB;
                end else if (w_timeout) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_MEM_RD;
                end
            end
            S_MEM_WR: begin
                if (dm_ready || w_timeout) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_MEM_WR;
                end
            end
            S_WB, S_BRANCH, S_JUMP: w_next_state = S_FETCH;
            default: w_next_state = S_FETCH;
        endcase
    end

    // Output decode; everything is held at 0 while reset is asserted.
    always_comb begin
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        alu_op      = 2'b00;
        alu_src_imm = 1'b0;
        dm_write    = 1'b0;
        dm_to_reg   = 1'b0;
        state       = 4'd0;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;
        if (!rst) begin
            state = r_state;
            case (r_state)
                S_FETCH: begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
                S_DECODE: begin
                    illegal_op = !f_is_legal(opcode, funct);
                end
                S_EXEC: begin
                    alu_op      = f_alu_op(r_opcode, r_funct);
                    alu_src_imm = f_alu_imm(r_opcode);
                end
                S_MEM_RD: begin
                    alu_op      = f_alu_op(r_opcode, r_funct);
                    alu_src_imm = f_alu_imm(r_opcode);
                    dm_to_reg   = 1'b1;
                    mem_timeout = w_timeout;
                end
                S_MEM_WR: begin
                    alu_op      = f_alu_op(r_opcode, r_funct);
                    alu_src_imm = f_alu_imm(r_opcode);
                    // Write is held while waiting, dropped on the abort cycle.
                    dm_write    = !w_timeout;
                    mem_timeout = w_timeout;
                    instr_done  = dm_ready;
                end
                S_WB: begin
                    alu_op      = f_alu_op(r_opcode, r_funct);
                    alu_src_imm = f_alu_imm(r_opcode);
                    reg_write   = 1'b1;
                    reg_dst     = (r_opcode == OP_RTYPE);
                    dm_to_reg   = (r_opcode == OP_LW);
                    instr_done  = 1'b1;
                end
                S_BRANCH: begin
                    alu_op     = 2'b10;
                    pc_src     = 2'b01;
                    pc_write   = alu_zero;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_src     = 2'b10;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
                default: begin
                    state = r_state;
                end
            endcase
        end else begin
            state = 4'd0;
        end
    end

`ifdef MC_PERF_CNT_EN
    logic [PERF_W-1:0] r_perf_cycles;
    logic [PERF_W-1:0] r_perf_retired;

    // Free-running performance counters, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cycles  <= {PERF_W{1'b0}};
            r_perf_retired <= {PERF_W{1'b0}};
        end else begin
            r_perf_cycles <= r_perf_cycles + PERF_W'(1);
            if (instr_done) begin
                r_perf_retired <= r_perf_retired + PERF_W'(1);
            end else begin
                r_perf_retired <= r_perf_retired;
            end
        end
    end

    assign perf_cycles  = rst ? {PERF_W{1'b0}} : r_perf_cycles;
    assign perf_retired = rst ? {PERF_W{1'b0}} : r_perf_retired;
`endif

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle control sequencer for the single-ALU MIPS datapath.
- Decodes opcode/funct from the instruction register and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives ALU operation select, ALU source select, data-memory write/read-select, register-file and PC strobes.
- Waits on a data-memory ready handshake, with a bounded timeout.

Parameters:
- MEM_WAIT_MAX, 15: maximum cycles spent in a MEM state waiting for dm_ready before abort; 0 = wait forever.
- PERF_W, 32: width of performance counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- opcode  in  6  instr[31:26] from IR
- funct  in  6  instr[5:0] from IR
- alu_zero  in  1  ALU zero flag
- dm_ready  in  1  data memory accepted write / read data valid
- ir_write  out  1  latch instruction into IR
- pc_write  out  1  update PC
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target
- reg_write  out  1  register-file write enable
- reg_dst  out  1  1 = rd, 0 = rt
- alu_op  out  2  00 add, 10 sub, 01 or, 11 lui
- alu_src_imm  out  1  ALU second operand is immediate
- dm_write  out  1  data memory write enable
- dm_to_reg  out  1  data memory read select (lw)
- state  out  4  current state encoding, debug
- instr_done  out  1  one-cycle pulse on instruction retire
- illegal_op  out  1  one-cycle pulse on undecodable instruction
- mem_timeout  out  1  one-cycle pulse on MEM abort

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM_RD=3, MEM_WR=4, WB=5, BRANCH=6, JUMP=7. Registered state; Moore outputs decoded from state plus latched opcode/funct.
- Reset: state<=FETCH, latched opcode/funct<=0, wait counter<=0. While rst=1, every output is 0 (strobes gated), including state=0. Reset mid-instruction abandons it with no further strobes.
- Supported opcodes:
  - R-type 000000 with funct 100000 (add) or 100010 (sub)
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010
- FETCH: ir_write=1, pc_write=1, pc_src=00 -> DECODE.
- DECODE: latch opcode/funct.
  - beq -> BRANCH; j -> JUMP; other legal -> EXEC.
  - Illegal: illegal_op=1 -> FETCH; no other strobes.
- EXEC: alu_op = 00 (add, lw, sw), 10 (sub), 01 (ori), 11 (lui). alu_src_imm=1 for ori/lui/lw/sw.
  - lw -> MEM_RD; sw -> MEM_WR; others -> WB.
- MEM_RD: dm_to_reg=1. Stay until dm_ready=1, then -> WB.
- MEM_WR: dm_write=1, held while waiting; rewriting the same address/data is benign. On dm_ready=1, instr_done=1 -> FETCH.
- MEM timeout: wait counter counts cycles in a MEM state with dm_ready=0. If MEM_WAIT_MAX != 0 and the count reaches MEM_WAIT_MAX: mem_timeout=1, dm_write=0 that cycle, -> FETCH with no reg_write. dm_ready=1 on the same cycle wins over timeout. Counter clears on MEM entry.
- alu_op and alu_src_imm hold their EXEC values through MEM_RD, MEM_WR and WB, so the address/result stays stable.
- WB: reg_write=1; reg_dst=1 for R-type else 0; dm_to_reg=1 for lw; instr_done=1 -> FETCH.
- BRANCH: alu_op=10, alu_src_imm=0, pc_src=01, pc_write=alu_zero, instr_done=1 -> FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1 -> FETCH.
- Latency with dm_ready tied high: R/ori/lui 4, lw 5, sw 4, beq 3, j 3, illegal 2 cycles.
- Undriven outputs in any state are 0. State encodings 8-15 are unreachable; if entered, -> FETCH with all strobes 0.

Optional Feature:
- MC_PERF_CNT_EN defined: adds outputs perf_cycles[PERF_W-1:0] and perf_retired[PERF_W-1:0].
  - perf_cycles increments every non-reset cycle.
  - perf_retired increments on instr_done.
  - Both wrap at 2^PERF_W and clear on rst.
- Undefined: these ports and counters do not exist.

Test Plan:
- Reset then add (opcode 0, funct 0x20), dm_ready=1 -> states 0,1,2,5; alu_op=00, alu_src_imm=0; WB has reg_write=1, reg_dst=1; instr_done on cycle 4.
- lw (0x23) with dm_ready low 3 cycles then high -> MEM_RD held 4 cycles with dm_to_reg=1, alu_op=00, alu_src_imm=1; WB has reg_write=1, reg_dst=0, dm_to_reg=1.
- sw (0x2B) with dm_ready never high, MEM_WAIT_MAX=15 -> dm_write high 15 cycles, mem_timeout pulse on the 16th MEM cycle with dm_write=0, back to FETCH, no reg_write.
- beq (0x04) with alu_zero=1 then 0 -> BRANCH pc_write=1 with pc_src=01 the first time, pc_write=0 the second; 3 cycles each.
- j (0x02) then illegal opcode 0x3F -> JUMP pc_src=10, pc_write=1; illegal_op pulse in DECODE, return to FETCH after 2 cycles.
- rst asserted during lw MEM_RD -> all outputs 0 while rst high; FETCH with ir_write=1 on the first cycle after release; with MC_PERF_CNT_EN, both counters read 0.
